// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN image loader: loader FSM states, default geometry
// and the flat-bus offset helper.
package cnn_pkg;

  localparam int unsigned N_CORES_DEF    = 4;
  localparam int unsigned IMG_SIZE_DEF   = 64;
  localparam int unsigned DATA_WIDTH_DEF = 32;

  typedef int unsigned uint_t;

  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  // Bit offset of word k of core c on the flattened image bus.
  function automatic uint_t flat_offset(input uint_t c, input uint_t k,
                                        input uint_t img_size, input uint_t dw);
    return (c * img_size + k) * dw;
  endfunction

endpackage

// File: rtl/img_index_counter.sv
// Nested pixel/core wrap counter that addresses the loader's image buffers.
module img_index_counter #(
  parameter int unsigned N_CORES  = 4,
  parameter int unsigned IMG_SIZE = 64,
  localparam int unsigned PW = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1,
  localparam int unsigned CW = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc_i,
  input  logic          clear_i,
  output logic [PW-1:0] pix_idx_o,
  output logic [CW-1:0] core_idx_o,
  output logic          pix_last_o,
  output logic          last_word_o
);

  logic [PW-1:0] pix_q;
  logic [CW-1:0] core_q;
  logic          core_last;

  assign pix_last_o  = (pix_q == PW'(IMG_SIZE - 1));
  assign core_last   = (core_q == CW'(N_CORES - 1));
  assign last_word_o = pix_last_o & core_last;
  assign pix_idx_o   = pix_q;
  assign core_idx_o  = core_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      pix_q  <= '0;
      core_q <= '0;
    end else if (inc_i) begin
      if (pix_last_o) begin
        pix_q  <= '0;
        core_q <= core_last ? '0 : core_q + 1'b1;
      end else begin
        pix_q <= pix_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cnn_image_loader.sv
// Demultiplexes a pixel stream into N_CORES image buffers, fires start, then waits for all_done.
// Optional s_last framing check: define IMG_LOADER_LAST_CHECK_EN.
module cnn_image_loader
  import cnn_pkg::*;
#(
  parameter int unsigned N_CORES    = N_CORES_DEF,
  parameter int unsigned IMG_SIZE   = IMG_SIZE_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  localparam int unsigned PW = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1,
  localparam int unsigned CW = (N_CORES > 1) ? $clog2(N_CORES) : 1,
  localparam int unsigned FLAT_W = N_CORES * IMG_SIZE * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic [FLAT_W-1:0]     images_flat,
  output logic                  start,
  input  logic                  all_done,
  output logic                  busy,
  output logic [15:0]           batch_count,
  output logic                  frame_err
);

  state_e        state_q;
  logic          start_q, busy_q, ferr_q;
  logic [15:0]   bc_q;
  logic [FLAT_W-1:0] img_q;

  logic [PW-1:0] pix_idx;
  logic [CW-1:0] core_idx;
  logic          pix_last, last_word;
  logic          hs, frame_bad, accept;

  assign s_ready = (state_q == LOAD);
  assign hs      = s_valid & s_ready;

`ifdef IMG_LOADER_LAST_CHECK_EN
  assign frame_bad = (s_last != pix_last);
`else
  logic unused_frame;
  assign unused_frame = s_last ^ pix_last;
  assign frame_bad    = 1'b0;
`endif

  assign accept = hs & ~frame_bad;

  img_index_counter #(
    .N_CORES (N_CORES),
    .IMG_SIZE(IMG_SIZE)
  ) u_idx (
    .clk_i      (clk),
    .rst_i      (rst),
    .inc_i      (accept),
    .clear_i    (hs & frame_bad),
    .pix_idx_o  (pix_idx),
    .core_idx_o (core_idx),
    .pix_last_o (pix_last),
    .last_word_o(last_word)
  );

  // Buffers only move on an accepted word, so the bus holds steady while cores run.
  always_ff @(posedge clk) begin
    if (rst) begin
      img_q <= '0;
    end else if (accept) begin
      img_q[flat_offset(uint_t'(core_idx), uint_t'(pix_idx), IMG_SIZE, DATA_WIDTH) +: DATA_WIDTH]
        <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      bc_q    <= '0;
    end else begin
      start_q <= 1'b0;
      ferr_q  <= hs & frame_bad;
      case (state_q)
        LOAD: begin
          if (accept && last_word) begin
            state_q <= START;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        START: state_q <= WAIT_DONE;
        WAIT_DONE: begin
          if (all_done) begin
            busy_q  <= 1'b0;
            bc_q    <= bc_q + 16'd1;
            state_q <= LOAD;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign images_flat = img_q;
  assign start       = start_q;
  assign busy        = busy_q;
  assign batch_count = bc_q;
  assign frame_err   = ferr_q;

endmodule

// File: tb/tb_cnn_image_loader.sv
// Directed bench for cnn_image_loader with a word-level reference model checked every cycle.
module tb_cnn_image_loader;

  localparam int N  = 4;
  localparam int S  = 64;
  localparam int DW = 32;
  localparam int T  = N * S;

  logic clk = 1'b0;
  logic rst, s_valid, s_last, all_done;
  logic [DW-1:0] s_data;
  logic s_ready, start, busy, frame_err;
  logic [T*DW-1:0] images_flat;
  logic [15:0] batch_count;

  // second, degenerate-geometry instance
  logic rst_s, sv_s, sl_s, ad_s, sr_s, st_s, bz_s, fe_s;
  logic [DW-1:0] images_s;
  logic [15:0] bc_s;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  cnn_image_loader #(.N_CORES(N), .IMG_SIZE(S), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .images_flat(images_flat), .start(start), .all_done(all_done),
    .busy(busy), .batch_count(batch_count), .frame_err(frame_err)
  );

  cnn_image_loader #(.N_CORES(1), .IMG_SIZE(1), .DATA_WIDTH(DW)) dut_s (
    .clk(clk), .rst(rst_s), .s_valid(sv_s), .s_ready(sr_s), .s_data(32'hA5A5_0F0F),
    .s_last(sl_s), .images_flat(images_s), .start(st_s), .all_done(ad_s),
    .busy(bz_s), .batch_count(bc_s), .frame_err(fe_s)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: batch word counter plus phase (0 loading, 1 start cycle, 2 waiting).
  logic [DW-1:0] m_img [T];
  int   m_cnt, m_ph;
  bit   m_start, m_busy, m_ferr;
  logic [15:0] m_bc;

  always @(posedge clk) begin
    if (rst) begin
      foreach (m_img[i]) m_img[i] = '0;
      m_cnt = 0; m_ph = 0; m_start = 0; m_busy = 0; m_ferr = 0; m_bc = '0;
    end else begin
      m_start = 0;
      m_ferr  = 0;
      case (m_ph)
        0: if (s_valid) begin
`ifdef IMG_LOADER_LAST_CHECK_EN
          if (s_last !== ((m_cnt % S) == S - 1)) begin
            m_ferr = 1;
            m_cnt  = 0;
          end else
`endif
          begin
            m_img[m_cnt] = s_data;
            m_cnt++;
            if (m_cnt == T) begin
              m_cnt = 0; m_ph = 1; m_start = 1; m_busy = 1;
            end
          end
        end
        1: m_ph = 2;
        default: if (all_done) begin
          m_busy = 0; m_bc = m_bc + 16'd1; m_ph = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int first_bad;
      first_bad = -1;
      chk("s_ready", {31'b0, s_ready}, {31'b0, m_ph == 0});
      chk("start", {31'b0, start}, {31'b0, m_start});
      chk("busy", {31'b0, busy}, {31'b0, m_busy});
      chk("batch_count", {16'b0, batch_count}, {16'b0, m_bc});
      chk("frame_err", {31'b0, frame_err}, {31'b0, m_ferr});
      for (int i = 0; i < T; i++)
        if (first_bad < 0 && images_flat[i*DW +: DW] !== m_img[i]) first_bad = i;
      if (first_bad < 0) chk("images_flat", 32'd0, 32'd0 + images_flat[0 +: 1] - images_flat[0 +: 1]);
      else chk("images_flat_word", images_flat[first_bad*DW +: DW], m_img[first_bad]);
    end
  end

  task automatic push(input logic [31:0] d, input logic last, output int t);
    int n;
    logic r;
    n = 0;
    s_valid = 1'b1; s_data = d; s_last = last;
    forever begin
      r = s_ready;
      @(posedge clk); #1;
      n++;
      if (r) break;
      if (n > 1000) begin
        total++; bad++;
        $display("FAIL push_timeout: got no s_ready expected s_ready within 1000 cycles");
        break;
      end
    end
    t = cyc;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic finish_batch();
    idle(2);
    all_done = 1'b1;
    idle(1);
    all_done = 1'b0;
  endtask

  function automatic logic [31:0] word_at(input int c, input int k);
    return images_flat[(c*S + k)*DW +: DW];
  endfunction

  initial begin
    int t, t_first;
    rst = 1'b1; s_valid = 0; s_last = 0; s_data = '0; all_done = 0;
    rst_s = 1'b1; sv_s = 0; sl_s = 1'b1; ad_s = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_ready", {31'b0, s_ready}, 32'd1);
    chk("rst_flat_zero", {31'b0, |images_flat}, 32'd0);

    // all-ones batch, valid held high
    for (int i = 0; i < T; i++) begin
      push(32'd1, (i % S) == S - 1, t);
      if (i == 0) t_first = t;
    end
    s_valid = 1'b0;
    chk("start_after_last", {31'b0, start}, 32'd1);
    chk("first_to_last_cycles", t - t_first, 32'd255);
    chk("ones_word0", word_at(0, 0), 32'd1);
    chk("ones_word_last", word_at(3, 63), 32'd1);
    chk("ones_busy", {31'b0, busy}, 32'd1);
    chk("ones_ready_low", {31'b0, s_ready}, 32'd0);
    finish_batch();
    rst = 1'b1; idle(1); rst = 1'b0;
    chk("reset_bc", {16'b0, batch_count}, 32'd0);

    // ascending words with random gaps, done 10 cycles after start
    for (int i = 0; i < T; i++) begin
      idle($urandom_range(0, 2));
      push(i, (i % S) == S - 1, t);
    end
    s_valid = 1'b0;
    idle(10);
    all_done = 1'b1;
    idle(1);
    all_done = 1'b0;
    chk("asc_bc", {16'b0, batch_count}, 32'd1);
    chk("asc_ready_after_done", {31'b0, s_ready}, 32'd1);
    chk("asc_c0k0", word_at(0, 0), 32'd0);
    chk("asc_c2k5", word_at(2, 5), 32'd133);
    chk("asc_c3k63", word_at(3, 63), 32'd255);

    // stale all_done held through loading
    all_done = 1'b1;
    for (int i = 0; i < T; i++) push(1000 + i, (i % S) == S - 1, t);
    s_valid = 1'b0;
    chk("stale_bc_at_start", {16'b0, batch_count}, 32'd1);
    idle(2);
    chk("stale_bc_after", {16'b0, batch_count}, 32'd2);
    all_done = 1'b0;

    // reset after 100 words
    for (int i = 0; i < 100; i++) push(7 + i, (i % S) == S - 1, t);
    s_valid = 1'b0;
    rst = 1'b1; idle(1); rst = 1'b0;
    chk("mid_rst_ready", {31'b0, s_ready}, 32'd1);
    chk("mid_rst_flat", {31'b0, |images_flat}, 32'd0);
    chk("mid_rst_bc", {16'b0, batch_count}, 32'd0);
    for (int i = 0; i < T; i++) push(i * 3, (i % S) == S - 1, t);
    s_valid = 1'b0;
    chk("fresh_start", {31'b0, start}, 32'd1);
    chk("fresh_c1k0", word_at(1, 0), 32'd192);
    finish_batch();

`ifdef IMG_LOADER_LAST_CHECK_EN
    for (int i = 0; i < 10; i++) push(50 + i, 1'b0, t);
    push(60, 1'b1, t);
    s_valid = 1'b0;
    chk("frame_err_pulse", {31'b0, frame_err}, 32'd1);
    chk("frame_no_start", {31'b0, start}, 32'd0);
    idle(1);
    chk("frame_err_one_cycle", {31'b0, frame_err}, 32'd0);
    for (int i = 0; i < T; i++) push(500 + i, (i % S) == S - 1, t);
    s_valid = 1'b0;
    chk("frame_recover_start", {31'b0, start}, 32'd1);
    finish_batch();
`endif

    // 1x1 geometry: one batch every 3 cycles with valid and all_done held
    @(posedge clk); #1;
    rst_s = 1'b0; sv_s = 1'b1; ad_s = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    chk("small_bc", {16'b0, bc_s}, 32'd100);
    chk("small_flat", images_s, 32'hA5A5_0F0F);
    chk("small_ferr", {31'b0, fe_s}, 32'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
